// File: rtl/reg_bank_pkg.sv
// Shared constants and select classification for the 8-entry register bank.
package reg_bank_pkg;

  localparam int unsigned NREG  = 8;
  localparam int unsigned IDX_W = 3;
  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    SEL_NONE  = 2'd0,
    SEL_ONE   = 2'd1,
    SEL_MULTI = 2'd2
  } sel_class_e;

endpackage

// File: rtl/onehot8_encoder.sv
// One-hot to binary encoder with legality classification; inverse of the 3-to-8 register decoder.
module onehot8_encoder
  import reg_bank_pkg::*;
(
  input  logic [NREG-1:0]  sel,
  output logic [IDX_W-1:0] idx_c,
  output sel_class_e       cls_c
);

  logic [3:0]       bit_cnt;
  logic [IDX_W-1:0] idx_or;

  // OR of set-bit positions equals the index only when exactly one bit is set
  always_comb begin
    bit_cnt = 4'd0;
    idx_or  = '0;
    idx_c   = '0;
    cls_c   = SEL_NONE;
    for (int i = 0; i < int'(NREG); i++) begin
      if (sel[i]) begin
        bit_cnt = bit_cnt + 4'd1;
        idx_or  = idx_or | IDX_W'(i);
      end
    end
    if (bit_cnt == 4'd1) begin
      cls_c = SEL_ONE;
      idx_c = idx_or;
    end else if (bit_cnt > 4'd1) begin
      cls_c = SEL_MULTI;
    end
  end

endmodule

// File: rtl/reg_bank_onehot_wr.sv
// 8-entry register bank written via one-hot select, two registered read ports with optional
// write-to-read bypass, last-write tracking and a sticky multi-hot error flag.
module reg_bank_onehot_wr
  import reg_bank_pkg::*;
#(
  parameter int unsigned DATA_W    = 16,
  parameter bit          BYPASS_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREG-1:0]   wr_sel,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [IDX_W-1:0]  rd_a_idx,
  input  logic [IDX_W-1:0]  rd_b_idx,
  output logic [DATA_W-1:0] rd_a_data,
  output logic [DATA_W-1:0] rd_b_data,
  output logic [IDX_W-1:0]  last_wr_idx,
  output logic              last_wr_vld,
  output logic [CNT_W-1:0]  wr_count,
  output logic              onehot_err,
  output logic [NREG-1:0]   err_sel
);

  logic [DATA_W-1:0] regs [NREG];
  logic [IDX_W-1:0]  wr_idx_c;
  sel_class_e        wr_cls_c;
  logic              wr_legal_c;
  logic              wr_multi_c;
  logic [DATA_W-1:0] rd_a_nxt_c;
  logic [DATA_W-1:0] rd_b_nxt_c;

  onehot8_encoder u_enc (
    .sel   (wr_sel),
    .idx_c (wr_idx_c),
    .cls_c (wr_cls_c)
  );

  assign wr_legal_c = (wr_cls_c == SEL_ONE);
  assign wr_multi_c = (wr_cls_c == SEL_MULTI);

  // Read muxes; each port resolves its bypass independently, multi-hot never forwards
  always_comb begin
    rd_a_nxt_c = regs[rd_a_idx];
    rd_b_nxt_c = regs[rd_b_idx];
    if (BYPASS_EN && wr_legal_c && (wr_idx_c == rd_a_idx)) begin
      rd_a_nxt_c = wr_data;
    end
    if (BYPASS_EN && wr_legal_c && (wr_idx_c == rd_b_idx)) begin
      rd_b_nxt_c = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NREG); i++) begin
        regs[i] <= '0;
      end
      rd_a_data   <= '0;
      rd_b_data   <= '0;
      last_wr_idx <= '0;
      last_wr_vld <= 1'b0;
      wr_count    <= '0;
      onehot_err  <= 1'b0;
      err_sel     <= '0;
    end else begin
      rd_a_data <= rd_a_nxt_c;
      rd_b_data <= rd_b_nxt_c;
      if (wr_legal_c) begin
        regs[wr_idx_c] <= wr_data;
        last_wr_idx    <= wr_idx_c;
        last_wr_vld    <= 1'b1;
        wr_count       <= wr_count + CNT_W'(1);
      end
      // Only the first offending select is kept for debug
      if (wr_multi_c && !onehot_err) begin
        onehot_err <= 1'b1;
        err_sel    <= wr_sel;
      end
    end
  end

endmodule
